// File: rtl/addsub_pkg.sv
// Shared types and helpers for the bit-serial add/sub sequencer.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Minimum of 1 so a counter always has at least one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/serial_addsub_cell.sv
// One-bit full adder; b is inverted when mode selects subtract.
module serial_addsub_cell (
    input  logic a,
    input  logic b,
    input  logic mode,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic bx;

    assign bx   = b ^ mode;
    assign sum  = a ^ bx ^ cin;
    assign cout = (a & bx) | (cin & (a ^ bx));

endmodule

// File: rtl/serial_addsub_seq.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, valid/ready on both sides.
// Define ADDSUB_OVERFLOW_EN to add the signed overflow output.
module serial_addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef ADDSUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = clog2(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_cat;
    logic             mode_q;
    logic             carry;
    logic             cell_sum;
    logic             cell_co;
    logic             accept;
    logic             last;

    serial_addsub_cell u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .mode (mode_q),
        .cin  (carry),
        .sum  (cell_sum),
        .cout (cell_co)
    );

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign last      = (state == RUN) && (cnt == CW'(WIDTH - 1));
    // Newest sum bit enters at the MSB; after WIDTH shifts the word is in order.
    assign res_cat   = {cell_sum, res_sr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            mode_q   <= MODE_ADD;
            carry    <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
`ifdef ADDSUB_OVERFLOW_EN
            overflow <= 1'b0;
`endif
        end else if (accept) begin
            state  <= RUN;
            cnt    <= '0;
            a_sr   <= a;
            b_sr   <= b;
            mode_q <= mode;
            // Carry-in of 1 completes the two's-complement negate of B.
            carry  <= mode;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_cat[WIDTH-1:1];
            carry  <= cell_co;
            cnt    <= cnt + 1'b1;
            if (last) begin
                state    <= DONE;
                result   <= res_cat;
                cout     <= cell_co;
`ifdef ADDSUB_OVERFLOW_EN
                overflow <= carry ^ cell_co;
`endif
            end
        end else if ((state == DONE) && out_ready) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Directed-vector bench with an expected-result queue drained by a monitor.
module tb_serial_addsub_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        cout;
`ifdef ADDSUB_OVERFLOW_EN
    logic        overflow;
`endif

    typedef struct {
        logic [15:0] r;
        logic        c;
        logic        o;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;

    serial_addsub_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout)
`ifdef ADDSUB_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every presented-and-accepted result is matched against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("result", {16'd0, result}, {16'd0, e.r});
                    chk("cout", {31'd0, cout}, {31'd0, e.c});
`ifdef ADDSUB_OVERFLOW_EN
                    chk("overflow", {31'd0, overflow}, {31'd0, e.o});
`endif
                end
            end
        end
    end

    // Called just after a rising edge; returns with in_valid low, just after the accept edge.
    task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic tm,
                        input logic [15:0] er, input logic ec, input logic eo,
                        output int waited);
        exp_t e;
        a = ta; b = tb_; mode = tm; in_valid = 1'b1;
        waited = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        e.r = er; e.c = ec; e.o = eo;
        q.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!out_valid && n < 100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic add with latency check.
        send(16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, 1'b0, w);
        wait_done(n);
        chk("latency_add", n, 32'd16);

        // Subtract both directions.
        send(16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, w);
        wait_done(n);
        send(16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, w);
        wait_done(n);
        chk("latency_sub", n, 32'd16);

        // Boundaries.
        send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, w);
        wait_done(n);
        send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, w);
        wait_done(n);
        send(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, w);
        wait_done(n);
        @(posedge clk);
        #1;

        // Backpressure: hold the result, then release with a new op on the same edge.
        out_ready = 1'b0;
        send(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, w);
        wait_done(n);
        chk("latency_bp", n, 32'd16);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_result", {16'd0, result}, 32'h0100);
            chk("bp_cout", {31'd0, cout}, 32'd0);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        send(16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, w);
        chk("bp_same_edge_accept", w, 32'd0);
        wait_done(n);
        chk("latency_after_bp", n, 32'd16);
        @(posedge clk);
        #1;

        // Reset mid-RUN discards the in-flight op.
        send(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, w);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_result", {16'd0, result}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        send(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, w);
        wait_done(n);
        chk("latency_post_rst", n, 32'd16);

        // Operand changes after accept must not affect the result.
        send(16'hA5A5, 16'h1111, 1'b0, 16'hB6B6, 1'b0, 1'b0, w);
        for (int i = 0; i < 16 && !out_valid; i++) begin
            a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom);
            @(posedge clk);
            #1;
        end
        send(16'h1000, 16'h2000, 1'b1, 16'hF000, 1'b0, 1'b0, w);
        for (int i = 0; i < 16 && !out_valid; i++) begin
            a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom);
            @(posedge clk);
            #1;
        end
        wait_done(n);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
